// File: rtl/execute_stage.sv
// RV32IM execute stage: operand forwarding, ALU, branch resolution, an iterative
// shift-add multiplier that stalls the front end, and the E/M pipeline register.
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic [31:0] rd1_e,
  input  logic [31:0] rd2_e,
  input  logic [31:0] imm_ext_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_plus4_e,
  input  logic [4:0]  rd_e,
  input  logic [2:0]  funct3_e,
  input  logic [3:0]  alu_control_e,
  input  logic        alu_src_e,
  input  logic [1:0]  forward_a_e,
  input  logic [1:0]  forward_b_e,
  input  logic [31:0] result_w,
  input  logic        reg_write_e,
  input  logic        mem_write_e,
  input  logic        jump_e,
  input  logic        branch_e,
  input  logic        jalr_e,
  input  logic [1:0]  result_src_e,
  input  logic        mul_e,
  input  logic [1:0]  mul_op_e,
  output logic        stall_e,
  output logic        pc_src_e,
  output logic [31:0] pc_target_e,
  output logic [4:0]  rd_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] write_data_m,
  output logic [31:0] pc_plus4_m,
  output logic        reg_write_m,
  output logic [1:0]  result_src_m,
  output logic        mem_write_m
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       mul_state;
  logic [CNT_W-1:0] mul_cnt;
  logic [63:0]      mcand;
  logic [63:0]      prod;
  logic [63:0]      signed_prod;
  logic [31:0]      mplier;
  logic [31:0]      mul_word;
  logic             mul_neg;
  logic [1:0]       mul_op;

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        a_neg;
  logic        b_neg;
  logic        cond;

  // Code 11 on either forward select falls back to the register-file operand.
  always_comb begin
    case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
    src_b = alu_src_e ? imm_ext_e : fwd_b;
  end

  always_comb begin
    case (alu_control_e)
      4'd0:    alu_result = src_a + src_b;
      4'd1:    alu_result = src_a - src_b;
      4'd2:    alu_result = src_a & src_b;
      4'd3:    alu_result = src_a | src_b;
      4'd4:    alu_result = src_a ^ src_b;
      4'd5:    alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
      4'd6:    alu_result = {31'b0, (src_a < src_b)};
      4'd7:    alu_result = src_a << src_b[4:0];
      4'd8:    alu_result = src_a >> src_b[4:0];
      4'd9:    alu_result = $signed(src_a) >>> src_b[4:0];
      4'd10:   alu_result = src_b;
      default: alu_result = 32'b0;
    endcase
  end

  // Branches compare the forwarded rs2 value, never the immediate.
  always_comb begin
    case (funct3_e)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a < fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign pc_src_e    = jump_e | (branch_e & cond);
  assign pc_target_e = jalr_e ? ((src_a + imm_ext_e) & 32'hFFFF_FFFE) : (pc_e + imm_ext_e);

  // MULHU treats both operands as unsigned, MULHSU only rs2; MUL/MULH are signed.
  assign a_neg = (mul_op_e != 2'b11) & src_a[31];
  assign b_neg = ~mul_op_e[1] & fwd_b[31];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -fwd_b : fwd_b;

  assign signed_prod = mul_neg ? -prod : prod;
  assign mul_word    = (mul_op == 2'b00) ? signed_prod[31:0] : signed_prod[63:32];

  assign stall_e = ((mul_state == IDLE) && mul_e) || (mul_state == BUSY);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      mul_state <= IDLE;
      mul_cnt   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      mul_neg   <= 1'b0;
      mul_op    <= 2'b00;
    end else begin
      case (mul_state)
        IDLE: begin
          if (mul_e) begin
            mcand     <= {32'b0, a_mag};
            mplier    <= b_mag;
            prod      <= '0;
            mul_neg   <= a_neg ^ b_neg;
            mul_op    <= mul_op_e;
            mul_cnt   <= '0;
            mul_state <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == LAST_ITER) mul_state <= DONE;
        end
        DONE:    mul_state <= IDLE;
        default: mul_state <= IDLE;
      endcase
    end
  end

  // A stalled cycle pushes an all-zero bubble; the DONE cycle carries the product.
  always_ff @(posedge clk) begin
    if (!srst_n || stall_e) begin
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
    end else begin
      rd_m         <= rd_e;
      alu_result_m <= (mul_state == DONE) ? mul_word : alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized ALU,
// branch and multiply traffic against a plain-arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        srst_n;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic [2:0]  funct3_e;
  logic [3:0]  alu_control_e;
  logic        alu_src_e, reg_write_e, mem_write_e, jump_e, branch_e, jalr_e, mul_e;
  logic [1:0]  forward_a_e, forward_b_e, result_src_e, mul_op_e;
  logic        stall_e, pc_src_e;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_alu_m;

  always #5 clk = ~clk;

  execute_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .srst_n(srst_n), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd_e(rd_e), .funct3_e(funct3_e),
    .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .result_w(result_w), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e), .jalr_e(jalr_e),
    .result_src_e(result_src_e), .mul_e(mul_e), .mul_op_e(mul_op_e), .stall_e(stall_e),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .mem_write_m(mem_write_m)
  );

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return 32'($signed(a) >>> b[4:0]);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  // Full-width sign/zero extension then a 64-bit product; the high or low word is selected.
  function automatic logic [31:0] model_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op <= 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic idle_inputs();
    rd1_e = '0; rd2_e = '0; imm_ext_e = '0; pc_e = '0; pc_plus4_e = '0; result_w = '0;
    rd_e = '0; funct3_e = '0; alu_control_e = '0; alu_src_e = 0; forward_a_e = '0;
    forward_b_e = '0; reg_write_e = 0; mem_write_e = 0; jump_e = 0; branch_e = 0;
    jalr_e = 0; result_src_e = '0; mul_e = 0; mul_op_e = '0;
  endtask

  task automatic test_reset();
    logic [104:0] em;
    idle_inputs();
    srst_n = 0;
    rd1_e = $urandom; rd2_e = $urandom; imm_ext_e = $urandom; pc_plus4_e = $urandom;
    rd_e = 5'd9; reg_write_e = 1; mem_write_e = 1; result_src_e = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    em = {rd_m, alu_result_m, write_data_m, pc_plus4_m, reg_write_m, result_src_m, mem_write_m};
    vectors++;
    if (em !== '0) begin miscompares++; $display("[TB] FAIL reset_em: got %h expected 0", em); end
    vectors++;
    if (stall_e !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_e); end
    idle_inputs();
    srst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    em = {rd_m, alu_result_m, write_data_m, pc_plus4_m, reg_write_m, result_src_m, mem_write_m};
    vectors++;
    if (em !== '0) begin miscompares++; $display("[TB] FAIL post_reset_em: got %h expected 0", em); end
    vectors++;
    if (stall_e !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_stall: got %b expected 0", stall_e); end
    exp_alu_m = '0;
  endtask

  task automatic test_directed_alu();
    idle_inputs();
    rd1_e = 32'd5; imm_ext_e = 32'd7; alu_src_e = 1; rd_e = 5'd3; reg_write_e = 1;
    @(posedge clk); #1;
    vectors++;
    if (alu_result_m !== 32'd12) begin miscompares++; $display("[TB] FAIL add_result: got %h expected %h", alu_result_m, 32'd12); end
    vectors++;
    if (rd_m !== 5'd3 || reg_write_m !== 1'b1) begin
      miscompares++; $display("[TB] FAIL add_ctrl: got rd=%0d rw=%b expected rd=3 rw=1", rd_m, reg_write_m);
    end
    idle_inputs();
    alu_control_e = 4'd1; forward_a_e = 2'b10; forward_b_e = 2'b01; result_w = 32'd20;
    rd1_e = 32'd99; rd2_e = 32'd77;
    @(posedge clk); #1;
    vectors++;
    if (alu_result_m !== 32'hFFFF_FFF8) begin miscompares++; $display("[TB] FAIL sub_fwd: got %h expected %h", alu_result_m, 32'hFFFF_FFF8); end
    vectors++;
    if (write_data_m !== 32'd20) begin miscompares++; $display("[TB] FAIL sub_wdata: got %h expected %h", write_data_m, 32'd20); end
    exp_alu_m = 32'hFFFF_FFF8;
  endtask

  task automatic test_branch();
    idle_inputs();
    rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1; branch_e = 1; funct3_e = 3'b100;
    pc_e = 32'h1000; imm_ext_e = 32'h20;
    #1;
    vectors++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h1020) begin
      miscompares++; $display("[TB] FAIL blt: got src=%b tgt=%h expected src=1 tgt=%h", pc_src_e, pc_target_e, 32'h1020);
    end
    funct3_e = 3'b110;
    #1;
    vectors++;
    if (pc_src_e !== 1'b0) begin miscompares++; $display("[TB] FAIL bltu: got %b expected 0", pc_src_e); end
    idle_inputs();
    rd1_e = 32'h101; imm_ext_e = 32'd4; jalr_e = 1; jump_e = 1; pc_e = 32'h8000;
    #1;
    vectors++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h104) begin
      miscompares++; $display("[TB] FAIL jalr: got src=%b tgt=%h expected src=1 tgt=%h", pc_src_e, pc_target_e, 32'h104);
    end
    idle_inputs();
    @(posedge clk); #1;
    exp_alu_m = '0;
  endtask

  task automatic test_random_alu(input int n);
    logic [31:0] a, b, sb, exp_res, exp_tgt;
    logic        exp_src;
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      rd1_e = $urandom; rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
      imm_ext_e = $urandom; pc_e = $urandom; pc_plus4_e = $urandom; result_w = $urandom;
      rd_e = 5'($urandom); funct3_e = 3'($urandom); alu_control_e = 4'($urandom);
      alu_src_e = 1'($urandom); forward_a_e = 2'($urandom); forward_b_e = 2'($urandom);
      reg_write_e = 1'($urandom); mem_write_e = 1'($urandom); result_src_e = 2'($urandom);
      jump_e = 1'($urandom); branch_e = 1'($urandom); jalr_e = 1'($urandom);
      a  = model_fwd(forward_a_e, rd1_e, result_w, exp_alu_m);
      b  = model_fwd(forward_b_e, rd2_e, result_w, exp_alu_m);
      sb = alu_src_e ? imm_ext_e : b;
      exp_res = model_alu(alu_control_e, a, sb);
      exp_src = jump_e | (branch_e & model_branch(funct3_e, a, b));
      exp_tgt = jalr_e ? ((a + imm_ext_e) & 32'hFFFF_FFFE) : (pc_e + imm_ext_e);
      #1;
      vectors++;
      if (pc_src_e !== exp_src || pc_target_e !== exp_tgt || stall_e !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand_pc[%0d]: got src=%b tgt=%h stall=%b expected src=%b tgt=%h stall=0",
                 i, pc_src_e, pc_target_e, stall_e, exp_src, exp_tgt);
      end
      @(posedge clk); #1;
      vectors++;
      if (alu_result_m !== exp_res || write_data_m !== b) begin
        miscompares++;
        $display("[TB] FAIL rand_alu[%0d] op=%0d: got res=%h wd=%h expected res=%h wd=%h",
                 i, alu_control_e, alu_result_m, write_data_m, exp_res, b);
      end
      vectors++;
      if ({rd_m, pc_plus4_m, reg_write_m, result_src_m, mem_write_m} !==
          {rd_e, pc_plus4_e, reg_write_e, result_src_e, mem_write_e}) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl[%0d]: got rd=%0d pc4=%h rw=%b rs=%0d mw=%b expected rd=%0d pc4=%h rw=%b rs=%0d mw=%b",
                 i, rd_m, pc_plus4_m, reg_write_m, result_src_m, mem_write_m,
                 rd_e, pc_plus4_e, reg_write_e, result_src_e, mem_write_e);
      end
      exp_alu_m = exp_res;
    end
  endtask

  task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    int cycles;
    idle_inputs();
    mul_e = 1; mul_op_e = op; rd1_e = a; rd2_e = b; alu_src_e = 1; imm_ext_e = $urandom;
    rd_e = 5'($urandom_range(1, 31)); reg_write_e = 1; result_src_e = 2'($urandom);
    pc_plus4_e = $urandom;
    exp_res = model_mul(op, a, b);
    #1;
    cycles = 0;
    while (stall_e === 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      vectors++;
      if (reg_write_m !== 1'b0 || mem_write_m !== 1'b0 || alu_result_m !== 32'd0 || rd_m !== 5'd0) begin
        miscompares++;
        $display("[TB] FAIL mul_bubble op=%0d cyc=%0d: got rw=%b mw=%b res=%h rd=%0d expected all 0",
                 op, cycles, reg_write_m, mem_write_m, alu_result_m, rd_m);
      end
      if (stall_e === 1'b1) begin
        forward_a_e = 2'($urandom); forward_b_e = 2'($urandom); result_w = $urandom;
      end else begin
        forward_a_e = 2'b00; forward_b_e = 2'b00;
      end
    end
    vectors++;
    if (cycles != 33) begin miscompares++; $display("[TB] FAIL mul_stall_len op=%0d: got %0d expected 33", op, cycles); end
    @(posedge clk); #1;
    vectors++;
    if (alu_result_m !== exp_res || rd_m !== rd_e || reg_write_m !== 1'b1 || pc_plus4_m !== pc_plus4_e) begin
      miscompares++;
      $display("[TB] FAIL mul_result op=%0d a=%h b=%h: got res=%h rd=%0d rw=%b expected res=%h rd=%0d rw=1",
               op, a, b, alu_result_m, rd_m, reg_write_m, exp_res, rd_e);
    end
    exp_alu_m = exp_res;
    idle_inputs();
  endtask

  task automatic test_mul();
    run_mul(2'b01, 32'hFFFF_FFFE, 32'd3);
    vectors++;
    if (alu_result_m !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL mulh_fixed: got %h expected %h", alu_result_m, 32'hFFFF_FFFF); end
    run_mul(2'b00, 32'h0001_0000, 32'h0001_0000);
    vectors++;
    if (alu_result_m !== 32'd0) begin miscompares++; $display("[TB] FAIL mul_fixed: got %h expected 0", alu_result_m); end
    run_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vectors++;
    if (alu_result_m !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL mulhu_fixed: got %h expected %h", alu_result_m, 32'hFFFF_FFFE); end
    run_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mul(2'b01, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++) run_mul(2'($urandom), $urandom, $urandom);
  endtask

  task automatic test_reset_busy();
    idle_inputs();
    mul_e = 1; mul_op_e = 2'b00; rd1_e = $urandom; rd2_e = $urandom;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (stall_e !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_stall: got %b expected 1", stall_e); end
    srst_n = 0; mul_e = 0;
    @(posedge clk); #1;
    vectors++;
    if (stall_e !== 1'b0 || alu_result_m !== 32'd0) begin
      miscompares++; $display("[TB] FAIL busy_abort: got stall=%b res=%h expected stall=0 res=0", stall_e, alu_result_m);
    end
    srst_n = 1;
    run_mul(2'b00, 32'd6, 32'd7);
    vectors++;
    if (alu_result_m !== 32'd42) begin miscompares++; $display("[TB] FAIL mul_after_abort: got %0d expected 42", alu_result_m); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    srst_n = 0;
    idle_inputs();
    exp_alu_m = '0;
    test_reset();
    test_directed_alu();
    test_branch();
    test_random_alu(60);
    test_mul();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
